// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Owns the load interface of a byte-level UART transmitter and arbitrates
//   three requesters into single-byte frames. The requesters are system
//   messages, paddle button commands (mode 0) and paddle position (mode 1).
//   Each frame is followed by an idle gap. Held buttons are rate-limited to one
//   command per repeat period. Only the newest position sample is kept.
//
//   Optional build macro: TX_SCHED_HEADER_EN
//     When defined, a position frame is two bytes: POS_HDR, then the position.
//     A full gap separates the two bytes. Nothing can interleave between them.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active low
//   mode       in   0 = button source enabled, 1 = position source enabled
//   btn_up     in   synchronised level (wins over btn_dn)
//   btn_dn     in   synchronised level
//   pos        in   paddle position
//   pos_valid  in   one-cycle strobe that latches pos
//   sys_valid  in   system byte offered
//   sys_data   in   system byte
//   sys_ready  out  system holding register empty
//   tx_start   out  one-cycle load strobe to the transmitter
//   tx_data    out  byte for the transmitter, held through the frame
//   tx_busy    in   transmitter is shifting a frame
//   grant_src  out  source of the frame in flight: 0 none, 1 sys, 2 btn, 3 pos
//   drop_cnt   out  overwritten position samples, saturating at 255
//   tx_err     out  one-cycle pulse when tx_busy never rose after tx_start
module uart_tx_scheduler #(
  parameter int unsigned CLK_FREQ    = 65_000_000,
  parameter int unsigned BAUD_RATE   = 9_600,
  parameter int unsigned GAP_BITS    = 2,
  parameter int unsigned BTN_PERIOD  = 1_083_333,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned DATA_W      = 8,
  parameter logic [DATA_W-1:0] CODE_UP = 8'h01,
  parameter logic [DATA_W-1:0] CODE_DN = 8'h80,
  parameter logic [DATA_W-1:0] POS_HDR = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              btn_up,
  input  logic              btn_dn,
  input  logic [DATA_W-1:0] pos,
  input  logic              pos_valid,
  input  logic              sys_valid,
  input  logic [DATA_W-1:0] sys_data,
  output logic              sys_ready,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic [1:0]        grant_src,
  output logic [7:0]        drop_cnt,
  output logic              tx_err
);

  localparam int unsigned BIT_CYC = CLK_FREQ / BAUD_RATE;
  localparam int unsigned GAP_CYC = GAP_BITS * BIT_CYC;
  localparam int unsigned TICK_W  = (BTN_PERIOD > 1) ? $clog2(BTN_PERIOD) : 1;
  localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned ACK_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BTN_PERIOD - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_SYS  = 2'd1;
  localparam logic [1:0] SRC_BTN  = 2'd2;
  localparam logic [1:0] SRC_POS  = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ACK   = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [ACK_W-1:0]    ack_q, ack_d;
  logic                mode_q;
  logic                sys_pend_q, sys_pend_d;
  logic [DATA_W-1:0]   sys_byte_q, sys_byte_d;
  logic                sys_ready_q, sys_ready_d;
  logic                btn_pend_q, btn_pend_d;
  logic [DATA_W-1:0]   btn_byte_q, btn_byte_d;
  logic                pos_pend_q, pos_pend_d;
  logic [DATA_W-1:0]   pos_byte_q, pos_byte_d;
  logic [7:0]          drop_q, drop_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [1:0]          src_q, src_d;
  logic                tx_err_q, tx_err_d;
`ifdef TX_SCHED_HEADER_EN
  logic                second_q, second_d;
  logic [DATA_W-1:0]   pos_hold_q, pos_hold_d;
`else
  logic                unused_pos_hdr;
  assign unused_pos_hdr = ^POS_HDR;
`endif

  logic tick;
  logic mode_chg;
  logic launch;
  logic grant_sys, grant_btn, grant_pos;

  assign tick     = (tick_q == TICK_LAST);
  // A mode switch invalidates whatever the old source had queued.
  assign mode_chg = (mode != mode_q);

  // Frame sequencer and arbiter
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    src_d      = src_q;
    tx_err_d   = 1'b0;
    ack_d      = ack_q;
    gap_d      = gap_q;
    launch     = 1'b0;
    grant_sys  = 1'b0;
    grant_btn  = 1'b0;
    grant_pos  = 1'b0;
`ifdef TX_SCHED_HEADER_EN
    second_d   = second_q;
    pos_hold_d = pos_hold_q;
`endif
    case (state_q)
      IDLE: begin
        // Never load while the transmitter still reports a frame in progress.
        if (!tx_busy) begin
`ifdef TX_SCHED_HEADER_EN
          if (second_q) begin
            // Second half of a position frame; it is not arbitrated.
            launch    = 1'b1;
            tx_data_d = pos_hold_q;
            src_d     = SRC_POS;
            second_d  = 1'b0;
          end else
`endif
          if (sys_pend_q) begin
            launch    = 1'b1;
            grant_sys = 1'b1;
            tx_data_d = sys_byte_q;
            src_d     = SRC_SYS;
          end else if (btn_pend_q && !mode_chg) begin
            launch    = 1'b1;
            grant_btn = 1'b1;
            tx_data_d = btn_byte_q;
            src_d     = SRC_BTN;
          end else if (pos_pend_q && !mode_chg) begin
            launch    = 1'b1;
            grant_pos = 1'b1;
            src_d     = SRC_POS;
`ifdef TX_SCHED_HEADER_EN
            tx_data_d  = POS_HDR;
            second_d   = 1'b1;
            pos_hold_d = pos_byte_q;
`else
            tx_data_d = pos_byte_q;
`endif
          end
        end
        if (launch) begin
          state_d    = START;
          tx_start_d = 1'b1;
        end
      end
      START: begin
        // The tx_start cycle counts as the first cycle of the ack window.
        state_d = ACK;
        ack_d   = ACK_W'(1);
      end
      ACK: begin
        if (tx_busy) begin
          state_d = DONE;
        end else if (ack_q == ACK_LAST) begin
          tx_err_d = 1'b1;
          state_d  = GAP;
          gap_d    = '0;
          src_d    = SRC_NONE;
`ifdef TX_SCHED_HEADER_EN
          second_d = 1'b0;
`endif
        end else begin
          ack_d = ack_q + 1'b1;
        end
      end
      DONE: begin
        if (!tx_busy) begin
          state_d = GAP;
          gap_d   = '0;
          src_d   = SRC_NONE;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        src_d   = SRC_NONE;
      end
    endcase
  end

  // Requester holding registers and repeat tick
  always_comb begin
    tick_d      = tick ? '0 : tick_q + 1'b1;
    sys_pend_d  = sys_pend_q;
    sys_byte_d  = sys_byte_q;
    sys_ready_d = sys_ready_q;
    btn_pend_d  = btn_pend_q & ~grant_btn;
    btn_byte_d  = btn_byte_q;
    pos_pend_d  = pos_pend_q & ~grant_pos;
    pos_byte_d  = pos_byte_q;
    drop_d      = drop_q;

    if (grant_sys) begin
      sys_pend_d  = 1'b0;
      sys_ready_d = 1'b1;
    end
    if (sys_valid && sys_ready_q) begin
      sys_pend_d  = 1'b1;
      sys_byte_d  = sys_data;
      sys_ready_d = 1'b0;
    end

    // The command byte is frozen at the tick, not at the grant.
    if (tick && !mode && (btn_up || btn_dn)) begin
      btn_pend_d = 1'b1;
      btn_byte_d = btn_up ? CODE_UP : CODE_DN;
    end

    // A sample arriving in the grant cycle is a fresh request, not a drop.
    if (pos_valid && mode && !mode_chg) begin
      pos_byte_d = pos;
      pos_pend_d = 1'b1;
      if (pos_pend_q && !grant_pos && (drop_q != 8'hFF)) begin
        drop_d = drop_q + 1'b1;
      end
    end

    if (mode_chg) begin
      btn_pend_d = 1'b0;
      pos_pend_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      gap_q       <= '0;
      ack_q       <= '0;
      mode_q      <= 1'b0;
      sys_pend_q  <= 1'b0;
      sys_byte_q  <= '0;
      sys_ready_q <= 1'b1;
      btn_pend_q  <= 1'b0;
      btn_byte_q  <= '0;
      pos_pend_q  <= 1'b0;
      pos_byte_q  <= '0;
      drop_q      <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      src_q       <= SRC_NONE;
      tx_err_q    <= 1'b0;
`ifdef TX_SCHED_HEADER_EN
      second_q    <= 1'b0;
      pos_hold_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      gap_q       <= gap_d;
      ack_q       <= ack_d;
      mode_q      <= mode;
      sys_pend_q  <= sys_pend_d;
      sys_byte_q  <= sys_byte_d;
      sys_ready_q <= sys_ready_d;
      btn_pend_q  <= btn_pend_d;
      btn_byte_q  <= btn_byte_d;
      pos_pend_q  <= pos_pend_d;
      pos_byte_q  <= pos_byte_d;
      drop_q      <= drop_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      src_q       <= src_d;
      tx_err_q    <= tx_err_d;
`ifdef TX_SCHED_HEADER_EN
      second_q    <= second_d;
      pos_hold_q  <= pos_hold_d;
`endif
    end
  end

  assign sys_ready = sys_ready_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign grant_src = src_q;
  assign drop_cnt  = drop_q;
  assign tx_err    = tx_err_q;

endmodule
